sssp_burst_worker: RTL and testbench

Parametrised SSSP edge-expansion worker for a tile's task unit. It consumes one vertex task and reads that vertex's offset pair. It then fetches the neighbour list in bounded bursts and emits one child task per surviving edge through a buffered output FIFO. Compared with the single-shot per-subtype worker, it adds:
- multi-burst chunking
- response flow control
- saturating distance arithmetic
- configurable timestamp pruning with a drop counter

---
 rtl/sssp_burst_worker.sv | 177 +++++++++++++++++
 tb/tb_sssp_burst_worker.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sssp_burst_worker.sv
// SSSP edge-expansion worker: reads a vertex's offset pair, fetches its neighbour
// list in bounded bursts and emits pruned child tasks through a small FIFO.
package sssp_pkg;
  typedef struct packed {
    logic [31:0] ts;
    logic [31:0] locale;
    logic [3:0]  ttype;
  } task_t;

  typedef logic [7:0] cq_slice_slot_t;

  typedef struct packed {
    logic        wvalid;
    logic [7:0]  waddr;
    logic [31:0] wdata;
  } reg_bus_t;

  localparam logic [7:0] OFFSET_BASE_ADDR   = 8'h00;
  localparam logic [7:0] NEIGHBOR_BASE_ADDR = 8'h04;
  localparam logic [7:0] SSSP_TS_LIMIT      = 8'h08;
endpackage

module sssp_burst_worker
  import sssp_pkg::*;
#(
  parameter int TILE_ID    = 0,
  parameter int MAX_BURST  = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           task_in_valid,
  output logic           task_in_ready,
  input  task_t          in_task,
  input  cq_slice_slot_t in_cq_slot,
  output logic           arvalid,
  input  logic           arready,
  output logic [31:0]    araddr,
  output logic [7:0]     arlen,
  output logic [2:0]     arsize,
  input  logic           rvalid,
  output logic           rready,
  input  logic [63:0]    rdata,
  input  logic           rlast,
  output logic           out_valid,
  input  logic           out_ready,
  output task_t          out_task,
  output cq_slice_slot_t out_cq_slot,
  output logic           busy,
  output logic [31:0]    log_output,
  input  reg_bus_t       reg_bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_OFF_REQ  = 3'd1;
  localparam logic [2:0] S_OFF_RESP = 3'd2;
  localparam logic [2:0] S_NBR_REQ  = 3'd3;
  localparam logic [2:0] S_NBR_RESP = 3'd4;
  localparam logic [2:0] S_DRAIN    = 3'd5;
  localparam logic [2:0] S_DONE     = 3'd6;

  if (MAX_BURST < 1 || MAX_BURST > 256 || (MAX_BURST & (MAX_BURST - 1)) != 0 ||
      FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TILE_ID < 0) begin : g_bad_param
    $error("sssp_burst_worker: illegal parameter set");
  end

  logic [2:0]     state;
  task_t          parent;
  cq_slice_slot_t parent_slot;
  logic [31:0]    cur_idx;
  logic [31:0]    end_idx;
  logic [31:0]    offset_base;
  logic [31:0]    nbr_base;
  logic [31:0]    ts_limit;

  task_t          fifo_task [FIFO_DEPTH];
  cq_slice_slot_t fifo_slot [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;

  logic [31:0] remaining;
  logic [31:0] burst_n;
  logic [31:0] beat_ts;
  logic        fifo_full;
  logic        beat_ok;
  logic        drop;
  logic        push;
  logic        pop;

  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  // cur never passes end, so remaining is the true count of unread edges
  assign remaining = end_idx - cur_idx;
  assign burst_n   = (remaining > 32'(MAX_BURST)) ? 32'(MAX_BURST) : remaining;
  assign beat_ts   = sat_add32(parent.ts, rdata[63:32]);
  assign drop      = beat_ts > ts_limit;
  assign fifo_full = (count == (PTR_W+1)'(FIFO_DEPTH));
  assign beat_ok   = (state == S_NBR_RESP) && rvalid && rready;
  assign push      = beat_ok && !drop;
  assign pop       = out_valid && out_ready;

  assign arvalid       = (state == S_OFF_REQ) || (state == S_NBR_REQ);
  assign araddr        = (state == S_NBR_REQ) ? nbr_base + (cur_idx << 3)
                                              : offset_base + (parent.locale << 2);
  assign arlen         = (state == S_NBR_REQ) ? 8'(burst_n - 32'd1) : 8'd0;
  assign arsize        = 3'd3;
  // Conservative flow control: never accept a beat while full, even if a pop is pending
  assign rready        = (state == S_OFF_RESP) || ((state == S_NBR_RESP) && !fifo_full);
  assign task_in_ready = (state == S_DONE);
  assign busy          = (state != S_IDLE);
  assign out_valid     = (count != '0);
  assign out_task      = fifo_task[rd_ptr];
  assign out_cq_slot   = fifo_slot[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= S_IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      log_output  <= '0;
      offset_base <= '0;
      nbr_base    <= '0;
      ts_limit    <= 32'hFFFF_FFFF;
    end else begin
      if (reg_bus.wvalid) begin
        case (reg_bus.waddr)
          OFFSET_BASE_ADDR:   offset_base <= reg_bus.wdata << 2;
          NEIGHBOR_BASE_ADDR: nbr_base    <= reg_bus.wdata << 2;
          SSSP_TS_LIMIT:      ts_limit    <= reg_bus.wdata;
          default: ;
        endcase
      end
      if (beat_ok && drop) log_output <= log_output + 32'd1;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: ;
      endcase
      case (state)
        S_IDLE:     if (task_in_valid) state <= S_OFF_REQ;
        S_OFF_REQ:  if (arready) state <= S_OFF_RESP;
        S_OFF_RESP: if (rvalid) state <= (rdata[31:0] >= rdata[63:32]) ? S_DONE : S_NBR_REQ;
        S_NBR_REQ:  if (arready) state <= S_NBR_RESP;
        S_NBR_RESP: if (beat_ok && rlast) state <= (cur_idx != end_idx) ? S_NBR_REQ : S_DRAIN;
        S_DRAIN:    if (count == '0) state <= S_DONE;
        S_DONE:     state <= S_IDLE;
        default:    state <= S_IDLE;
      endcase
    end
  end

  // Datapath registers carry no reset; the FSM decides when they are meaningful
  always_ff @(posedge clk) begin
    if (state == S_IDLE && task_in_valid) begin
      parent      <= in_task;
      parent_slot <= in_cq_slot;
    end
    if (state == S_OFF_RESP && rvalid) begin
      cur_idx <= rdata[31:0];
      end_idx <= rdata[63:32];
    end
    if (state == S_NBR_REQ && arready) cur_idx <= cur_idx + burst_n;
    if (push) begin
      fifo_task[wr_ptr] <= '{ts: beat_ts, locale: rdata[31:0], ttype: parent.ttype};
      fifo_slot[wr_ptr] <= parent_slot;
    end
  end
endmodule

// File: tb/tb_sssp_burst_worker.sv
// Directed bench for sssp_burst_worker with a burst-capable memory responder.
module tb_sssp_burst_worker;
  import sssp_pkg::*;

  typedef struct packed {
    logic [31:0] locale;
    logic [31:0] ts;
    logic [3:0]  ttype;
    logic [7:0]  slot;
  } child_t;

  typedef struct {
    int unsigned addr;
    int unsigned len;
  } burst_t;

  logic           clk;
  logic           rstn;
  logic           task_in_valid;
  logic           task_in_ready;
  task_t          in_task;
  cq_slice_slot_t in_cq_slot;
  logic           arvalid;
  logic           arready;
  logic [31:0]    araddr;
  logic [7:0]     arlen;
  logic [2:0]     arsize;
  logic           rvalid;
  logic           rready;
  logic [63:0]    rdata;
  logic           rlast;
  logic           out_valid;
  logic           out_ready;
  task_t          out_task;
  cq_slice_slot_t out_cq_slot;
  logic           busy;
  logic [31:0]    log_output;
  reg_bus_t       reg_bus;

  sssp_burst_worker #(.TILE_ID(0), .MAX_BURST(16), .FIFO_DEPTH(8)) dut (
    .clk(clk), .rstn(rstn),
    .task_in_valid(task_in_valid), .task_in_ready(task_in_ready),
    .in_task(in_task), .in_cq_slot(in_cq_slot),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rlast(rlast),
    .out_valid(out_valid), .out_ready(out_ready), .out_task(out_task), .out_cq_slot(out_cq_slot),
    .busy(busy), .log_output(log_output), .reg_bus(reg_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic [63:0] mem [int unsigned];
  burst_t pend [$];
  burst_t ar_log [$];
  child_t child_q [$];
  burst_t addr_burst;
  logic   beat_taken = 1'b0;
  logic   addr_taken = 1'b0;
  int     beats_acc = 0;
  int     ov_cnt = 0;
  int     retire_cnt = 0;
  int     kids_at_retire = 0;
  int     retire_base, child_base, ar_base, beats_base, ov_base;

  function automatic logic [63:0] mem_rd(input int unsigned a);
    return mem.exists(a) ? mem[a] : 64'h0;
  endfunction

  always @(posedge clk) begin
    beat_taken <= rvalid && rready;
    addr_taken <= arvalid && arready;
    addr_burst <= '{araddr, 32'(arlen)};
    if (rstn) begin
      if (arvalid && arready) ar_log.push_back('{araddr, 32'(arlen)});
      if (rvalid && rready) beats_acc <= beats_acc + 1;
      if (out_valid && out_ready)
        child_q.push_back('{out_task.locale, out_task.ts, out_task.ttype, out_cq_slot});
      if (out_valid) ov_cnt <= ov_cnt + 1;
      if (task_in_ready) begin
        retire_cnt <= retire_cnt + 1;
        kids_at_retire <= child_q.size();
      end
    end
  end

  // Memory responder: always accepts addresses, returns beats back to back
  initial begin : mem_slave
    int unsigned bidx;
    bidx = 0;
    arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rdata = '0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        pend.delete(); bidx = 0;
        arready = 1'b0; rvalid = 1'b0; rlast = 1'b0;
      end else begin
        if (beat_taken && pend.size() != 0) begin
          if (bidx == pend[0].len) begin
            void'(pend.pop_front());
            bidx = 0;
          end else bidx++;
        end
        if (addr_taken) pend.push_back(addr_burst);
        arready = 1'b1;
        if (pend.size() != 0) begin
          rvalid = 1'b1;
          rdata  = mem_rd(pend[0].addr + 8 * bidx);
          rlast  = (bidx == pend[0].len);
        end else begin
          rvalid = 1'b0; rlast = 1'b0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic reg_write(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    reg_bus = '{wvalid: 1'b1, waddr: a, wdata: d};
    @(negedge clk);
    reg_bus = '{wvalid: 1'b0, waddr: 8'h0, wdata: 32'h0};
  endtask

  task automatic start_task(input logic [31:0] ts, input logic [31:0] loc,
                            input logic [3:0] tt, input logic [7:0] slot);
    @(negedge clk);
    retire_base = retire_cnt; child_base = child_q.size(); ar_base = ar_log.size();
    beats_base = beats_acc; ov_base = ov_cnt;
    task_in_valid = 1'b1;
    in_task = '{ts: ts, locale: loc, ttype: tt};
    in_cq_slot = slot;
    @(negedge clk);
    task_in_valid = 1'b0;
  endtask

  task automatic wait_retire(input int budget, input string name);
    int n;
    n = 0;
    while (retire_cnt == retire_base && n < budget) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (retire_cnt == retire_base) begin
      bad++;
      $display("FAIL %s_retire: no task_in_ready within %0d cycles", name, budget);
    end
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    task_in_valid = 1'b0; in_task = '0; in_cq_slot = '0; out_ready = 1'b1;
    reg_bus = '{wvalid: 1'b0, waddr: 8'h0, wdata: 32'h0};
    repeat (3) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    total++; if (arvalid !== 1'b0) begin bad++; $display("FAIL rst_arvalid: got %b want 0", arvalid); end
    total++; if (rready !== 1'b0) begin bad++; $display("FAIL rst_rready: got %b want 0", rready); end
    total++; if (task_in_ready !== 1'b0) begin bad++; $display("FAIL rst_task_in_ready: got %b want 0", task_in_ready); end
    total++; if (arsize !== 3'd3) begin bad++; $display("FAIL rst_arsize: got %0d want 3", arsize); end
    total++; if (arlen !== 8'd0) begin bad++; $display("FAIL rst_arlen: got %0d want 0", arlen); end
    total++; if (log_output !== 32'd0) begin bad++; $display("FAIL rst_log: got %0d want 0", log_output); end
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic(input string name);
    child_t exp;
    start_task(32'd100, 32'd3, 4'd2, 8'h5A);
    total++; if (arvalid !== 1'b1 || araddr !== 32'h40C || arlen !== 8'd0) begin
      bad++; $display("FAIL %s_off_req: arvalid=%b araddr=%h arlen=%0d want 1/0000040c/0", name, arvalid, araddr, arlen);
    end
    wait_retire(100, name);
    total++; if (ar_log.size() - ar_base != 2) begin
      bad++; $display("FAIL %s_ar_count: got %0d want 2", name, ar_log.size() - ar_base);
    end else begin
      total++; if (ar_log[ar_base + 1].addr != 32'h4050 || ar_log[ar_base + 1].len != 2) begin
        bad++; $display("FAIL %s_nbr_req: addr=%h len=%0d want 4050/2", name, ar_log[ar_base + 1].addr, ar_log[ar_base + 1].len);
      end
    end
    total++; if (child_q.size() - child_base != 3) begin
      bad++; $display("FAIL %s_child_count: got %0d want 3", name, child_q.size() - child_base);
    end else begin
      for (int i = 0; i < 3; i++) begin
        exp = '{32'(4 + i), 32'(105 + 2 * i), 4'd2, 8'h5A};
        total++; if (child_q[child_base + i] !== exp) begin
          bad++; $display("FAIL %s_child%0d: got %h want %h", name, i, child_q[child_base + i], exp);
        end
      end
    end
    total++; if (kids_at_retire - child_base != 3) begin
      bad++; $display("FAIL %s_retire_order: pops before retire %0d want 3", name, kids_at_retire - child_base);
    end
    repeat (2) @(negedge clk);
    total++; if (retire_cnt - retire_base != 1 || busy !== 1'b0) begin
      bad++; $display("FAIL %s_single_pulse: pulses=%0d busy=%b want 1/0", name, retire_cnt - retire_base, busy);
    end
  endtask

  task automatic test_multi_burst;
    child_t exp;
    start_task(32'd0, 32'd10, 4'd1, 8'h11);
    wait_retire(200, "multi");
    total++; if (ar_log.size() - ar_base != 3) begin
      bad++; $display("FAIL multi_ar_count: got %0d want 3", ar_log.size() - ar_base);
    end else begin
      total++; if (ar_log[ar_base + 1].addr != 32'h4320 || ar_log[ar_base + 1].len != 15) begin
        bad++; $display("FAIL multi_burst1: addr=%h len=%0d want 4320/15", ar_log[ar_base + 1].addr, ar_log[ar_base + 1].len);
      end
      total++; if (ar_log[ar_base + 2].addr != 32'h43A0 || ar_log[ar_base + 2].len != 3) begin
        bad++; $display("FAIL multi_burst2: addr=%h len=%0d want 43a0/3", ar_log[ar_base + 2].addr, ar_log[ar_base + 2].len);
      end
    end
    total++; if (child_q.size() - child_base != 20) begin
      bad++; $display("FAIL multi_child_count: got %0d want 20", child_q.size() - child_base);
    end else begin
      for (int i = 0; i < 20; i++) begin
        exp = '{32'(1000 + i), 32'(i + 1), 4'd1, 8'h11};
        total++; if (child_q[child_base + i] !== exp) begin
          bad++; $display("FAIL multi_child%0d: got %h want %h", i, child_q[child_base + i], exp);
        end
      end
    end
  endtask

  task automatic test_empty(input logic [31:0] loc, input string name);
    start_task(32'd7, loc, 4'd3, 8'h22);
    wait_retire(50, name);
    repeat (2) @(negedge clk);
    total++; if (ar_log.size() - ar_base != 1) begin
      bad++; $display("FAIL %s_ar_count: got %0d want 1", name, ar_log.size() - ar_base);
    end
    total++; if (ov_cnt != ov_base) begin
      bad++; $display("FAIL %s_out_valid: high for %0d cycles want 0", name, ov_cnt - ov_base);
    end
  endtask

  task automatic test_ts_limit;
    child_t exp;
    reg_write(SSSP_TS_LIMIT, 32'd106);
    start_task(32'd100, 32'd3, 4'd2, 8'h33);
    wait_retire(100, "limit");
    exp = '{32'd4, 32'd105, 4'd2, 8'h33};
    total++; if (child_q.size() - child_base != 1) begin
      bad++; $display("FAIL limit_child_count: got %0d want 1", child_q.size() - child_base);
    end else if (child_q[child_base] !== exp) begin
      bad++; $display("FAIL limit_child: got %h want %h", child_q[child_base], exp);
    end
    total++; if (log_output !== 32'd2) begin bad++; $display("FAIL limit_log: got %0d want 2", log_output); end
    reg_write(SSSP_TS_LIMIT, 32'hFFFF_FFFF);
  endtask

  task automatic test_saturate;
    child_t exp;
    start_task(32'hFFFF_FFF0, 32'd30, 4'd5, 8'h44);
    wait_retire(100, "sat");
    exp = '{32'd77, 32'hFFFF_FFFF, 4'd5, 8'h44};
    total++; if (child_q.size() - child_base != 1) begin
      bad++; $display("FAIL sat_child_count: got %0d want 1", child_q.size() - child_base);
    end else if (child_q[child_base] !== exp) begin
      bad++; $display("FAIL sat_child: got %h want %h", child_q[child_base], exp);
    end
    total++; if (log_output !== 32'd2) begin bad++; $display("FAIL sat_log: got %0d want 2", log_output); end
  endtask

  task automatic test_backpressure;
    child_t exp;
    out_ready = 1'b0;
    start_task(32'd10, 32'd40, 4'd6, 8'h55);
    repeat (20) @(negedge clk);
    total++; if (beats_acc - beats_base != 9) begin
      bad++; $display("FAIL bp_beats_held: accepted %0d beats want 9 (offset + 8)", beats_acc - beats_base);
    end
    total++; if (rready !== 1'b0 || out_valid !== 1'b1) begin
      bad++; $display("FAIL bp_full: rready=%b out_valid=%b want 0/1", rready, out_valid);
    end
    out_ready = 1'b1;
    wait_retire(200, "bp");
    total++; if (child_q.size() - child_base != 12) begin
      bad++; $display("FAIL bp_child_count: got %0d want 12", child_q.size() - child_base);
    end else begin
      for (int i = 0; i < 12; i++) begin
        exp = '{32'(500 + i), 32'd11, 4'd6, 8'h55};
        total++; if (child_q[child_base + i] !== exp) begin
          bad++; $display("FAIL bp_child%0d: got %h want %h", i, child_q[child_base + i], exp);
        end
      end
    end
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b0;
    start_task(32'd10, 32'd40, 4'd6, 8'h66);
    repeat (8) @(negedge clk);
    total++; if (busy !== 1'b1 || out_valid !== 1'b1) begin
      bad++; $display("FAIL mid_pre: busy=%b out_valid=%b want 1/1", busy, out_valid);
    end
    rstn = 1'b0;
    @(negedge clk);
    total++; if (busy !== 1'b0 || out_valid !== 1'b0) begin
      bad++; $display("FAIL mid_reset: busy=%b out_valid=%b want 0/0", busy, out_valid);
    end
    total++; if (log_output !== 32'd0 || rready !== 1'b0 || arvalid !== 1'b0) begin
      bad++; $display("FAIL mid_reset_ctl: log=%0d rready=%b arvalid=%b want 0/0/0", log_output, rready, arvalid);
    end
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    mem[32'h40C] = {32'd13, 32'd10};
    mem[32'h4050] = {32'd5, 32'd4};
    mem[32'h4058] = {32'd7, 32'd5};
    mem[32'h4060] = {32'd9, 32'd6};
    mem[32'h428] = {32'd120, 32'd100};
    for (int i = 0; i < 20; i++) mem[32'h4320 + 8 * i] = {32'(i + 1), 32'(1000 + i)};
    mem[32'h450] = {32'd50, 32'd50};
    mem[32'h458] = {32'd10, 32'd30};
    mem[32'h478] = {32'd201, 32'd200};
    mem[32'h4640] = {32'h100, 32'd77};
    mem[32'h4A0] = {32'd312, 32'd300};
    for (int i = 0; i < 12; i++) mem[32'h4960 + 8 * i] = {32'd1, 32'(500 + i)};

    test_reset();
    reg_write(OFFSET_BASE_ADDR, 32'h100);
    reg_write(NEIGHBOR_BASE_ADDR, 32'h1000);
    test_basic("basic");
    test_multi_burst();
    test_empty(32'd20, "empty");
    test_empty(32'd22, "neg");
    test_ts_limit();
    test_saturate();
    test_backpressure();
    test_reset_mid();
    reg_write(OFFSET_BASE_ADDR, 32'h100);
    reg_write(NEIGHBOR_BASE_ADDR, 32'h1000);
    test_basic("recover");
    total++; if (log_output !== 32'd0) begin bad++; $display("FAIL recover_log: got %0d want 0", log_output); end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
